// File: rtl/skewed_accumulator_pkg.sv
// Shared FSM state type and sign-extend / saturating-add helpers for the skewed accumulator.
package skewed_accumulator_pkg;

    typedef enum logic [1:0] {StIdle, StCollect, StDrain} state_e;

    localparam int unsigned MaxWidth = 64;

    // Sign-extends the low `width` bits of value to the full MaxWidth.
    function automatic logic [MaxWidth-1:0] sign_extend(input logic [MaxWidth-1:0] value,
                                                        input int unsigned width);
        logic signed [MaxWidth-1:0] shifted;
        shifted = value << (MaxWidth - width);
        return shifted >>> (MaxWidth - width);
    endfunction

    // Adds two width-bit signed values (given sign-extended); clamps or wraps to width bits.
    function automatic logic [MaxWidth-1:0] sat_add(input logic [MaxWidth-1:0] a,
                                                    input logic [MaxWidth-1:0] b,
                                                    input int unsigned width,
                                                    input logic saturate);
        logic signed [MaxWidth:0] sum;
        logic signed [MaxWidth:0] hi;
        logic signed [MaxWidth:0] lo;
        logic [MaxWidth-1:0] result;
        sum = $signed({a[MaxWidth-1], a}) + $signed({b[MaxWidth-1], b});
        hi = (65'sd1 <<< (width - 1)) - 65'sd1;
        lo = -(65'sd1 <<< (width - 1));
        if (saturate && (sum > hi)) begin
            result = hi[MaxWidth-1:0];
        end else if (saturate && (sum < lo)) begin
            result = lo[MaxWidth-1:0];
        end else begin
            result = sign_extend(sum[MaxWidth-1:0], width);
        end
        return result;
    endfunction

endpackage

// File: rtl/skewed_accumulator_acc_lane.sv
// One accumulator column: DEPTH entries with overwrite/accumulate write port,
// combinational read port and a read-and-clear port used while draining.
module acc_lane
    import skewed_accumulator_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SATURATE  = 0,
    localparam int unsigned RowWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [RowWidth-1:0]  wr_row,
    input  logic                 first,
    input  logic [IN_WIDTH-1:0]  din,
    input  logic                 clr_en,
    input  logic [RowWidth-1:0]  clr_row,
    input  logic [RowWidth-1:0]  rd_row,
    output logic [ACC_WIDTH-1:0] rd_data
);

    logic [ACC_WIDTH-1:0] mem_q [DEPTH];
    logic [MaxWidth-1:0]  din_ext;
    logic [MaxWidth-1:0]  acc_ext;
    logic [MaxWidth-1:0]  sum;
    logic [ACC_WIDTH-1:0] wr_data;

    always_comb begin
        din_ext = sign_extend(MaxWidth'(din), IN_WIDTH);
        acc_ext = sign_extend(MaxWidth'(mem_q[wr_row]), ACC_WIDTH);
        sum     = sat_add(acc_ext, din_ext, ACC_WIDTH, SATURATE != 0);
        wr_data = first ? ACC_WIDTH'(din_ext) : ACC_WIDTH'(sum);
    end

    // Writes and clears never coincide: writes happen only while collecting.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_row] <= wr_data;
        end else if (clr_en) begin
            mem_q[clr_row] <= '0;
        end
    end

    assign rd_data = mem_q[rd_row];

endmodule

// File: rtl/skewed_accumulator.sv
// Skewed tile accumulator: column c takes row t-c at skew cycle t, then drains
// row by row over a valid/ready port with read-and-clear.
module skewed_accumulator
    import skewed_accumulator_pkg::*;
#(
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ARRAY_M   = 8,
    parameter int unsigned IN_WIDTH  = 32,
    parameter int unsigned ACC_WIDTH = 32,
    parameter int unsigned SATURATE  = 0,
    localparam int unsigned ColWidth = $clog2(ARRAY_M) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ARRAY_M*IN_WIDTH-1:0]  data_set_in,
    input  logic                         on,
    input  logic                         first,
    input  logic [ColWidth-1:0]          num_cols,
    input  logic                         drain,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [ARRAY_M*ACC_WIDTH-1:0] acc_out,
    output logic                         busy,
    output logic                         done
);

    localparam int unsigned RowWidth  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SkewWidth = $clog2(DEPTH + ARRAY_M) + 1;
    localparam int unsigned TLast     = DEPTH + ARRAY_M - 2;
    localparam int unsigned RLast     = DEPTH - 1;

    state_e                       state_q, state_d;
    logic [SkewWidth-1:0]         t_q;
    logic                         first_q;
    logic [ColWidth-1:0]          cols_q;
    logic [RowWidth-1:0]          row_q;
    logic                         out_valid_q;
    logic [ARRAY_M*ACC_WIDTH-1:0] acc_out_q;
    logic                         done_q;

    logic                         start_collect, start_drain, advance, collect_last;
    logic                         xfer, last_row, first_cur;
    logic [SkewWidth-1:0]         t_cur;
    logic [ColWidth-1:0]          cols_in, cols_cur;
    logic [RowWidth-1:0]          rd_row;
    logic [ARRAY_M*ACC_WIDTH-1:0] row_masked;

    // The starting cycle in IDLE is already skew cycle 0, so it uses the live inputs.
    always_comb begin
        cols_in       = (num_cols > ColWidth'(ARRAY_M)) ? ColWidth'(ARRAY_M) : num_cols;
        start_drain   = (state_q == StIdle) && drain;
        start_collect = (state_q == StIdle) && on && !drain;
        advance       = start_collect || ((state_q == StCollect) && on);
        t_cur         = start_collect ? '0 : t_q;
        first_cur     = start_collect ? first : first_q;
        cols_cur      = start_collect ? cols_in : cols_q;
        collect_last  = advance && (t_cur == SkewWidth'(TLast));
        xfer          = (state_q == StDrain) && out_valid_q && out_ready;
        last_row      = (row_q == RowWidth'(RLast));
        rd_row        = (xfer && !last_row) ? row_q + RowWidth'(1) : row_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start_drain) begin
                    state_d = StDrain;
                end else if (start_collect && !collect_last) begin
                    state_d = StCollect;
                end
            end
            StCollect: begin
                if (collect_last) begin
                    state_d = StIdle;
                end
            end
            StDrain: begin
                if (xfer && last_row) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy      = (state_q != StIdle);
        done      = done_q;
        out_valid = out_valid_q;
        acc_out   = acc_out_q;
    end

    for (genvar c = 0; c < ARRAY_M; c++) begin : g_lane
        logic [SkewWidth-1:0] rel;
        logic                 we;
        logic [ACC_WIDTH-1:0] rd_data;

        assign rel = t_cur - SkewWidth'(c);
        assign we  = advance && (t_cur >= SkewWidth'(c)) && (rel < SkewWidth'(DEPTH)) &&
                     (ColWidth'(c) < cols_cur);

        acc_lane #(
            .DEPTH    (DEPTH),
            .IN_WIDTH (IN_WIDTH),
            .ACC_WIDTH(ACC_WIDTH),
            .SATURATE (SATURATE)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (we),
            .wr_row (RowWidth'(rel)),
            .first  (first_cur),
            .din    (data_set_in[c*IN_WIDTH +: IN_WIDTH]),
            .clr_en (xfer),
            .clr_row(row_q),
            .rd_row (rd_row),
            .rd_data(rd_data)
        );

        assign row_masked[c*ACC_WIDTH +: ACC_WIDTH] = (ColWidth'(c) < cols_q) ? rd_data : '0;
    end

    // During DRAIN, cols_q holds the column count sampled at drain start.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            t_q         <= '0;
            first_q     <= 1'b0;
            cols_q      <= '0;
            row_q       <= '0;
            out_valid_q <= 1'b0;
            acc_out_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            done_q <= collect_last;
            if (advance) begin
                t_q     <= collect_last ? '0 : t_cur + SkewWidth'(1);
                first_q <= first_cur;
                cols_q  <= cols_cur;
            end
            if (start_drain) begin
                cols_q <= cols_in;
                row_q  <= '0;
            end
            if (state_q == StDrain) begin
                if (!out_valid_q) begin
                    out_valid_q <= 1'b1;
                    acc_out_q   <= row_masked;
                end else if (out_ready) begin
                    if (last_row) begin
                        out_valid_q <= 1'b0;
                        row_q       <= '0;
                    end else begin
                        row_q     <= row_q + RowWidth'(1);
                        acc_out_q <= row_masked;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_skewed_accumulator.sv
// Bench for skewed_accumulator: a 32-bit wrapping instance plus 8-bit saturating and
// wrapping instances sharing one stimulus, checked against an array model of the tile.
module tb_skewed_accumulator;

    localparam int D     = 8;
    localparam int M     = 8;
    localparam int W     = 32;
    localparam int SW    = 8;
    localparam int CW    = 4;
    localparam int TLAST = D + M - 2;

    typedef logic [M*W-1:0]  wide_t;
    typedef logic [M*SW-1:0] narrow_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    wide_t         data_main;
    narrow_t       data_small;
    logic          on, first, drain, out_ready;
    logic [CW-1:0] num_cols;
    logic          ov_m, ov_s, ov_w, busy_m, busy_s, busy_w, done_m, done_s, done_w;
    wide_t         acc_m;
    narrow_t       acc_s, acc_w;

    always #5 clk = ~clk;

    skewed_accumulator #(
        .DEPTH(D), .ARRAY_M(M), .IN_WIDTH(W), .ACC_WIDTH(W), .SATURATE(0)
    ) dut_main (
        .clk(clk), .reset(reset), .data_set_in(data_main), .on(on), .first(first),
        .num_cols(num_cols), .drain(drain), .out_ready(out_ready), .out_valid(ov_m),
        .acc_out(acc_m), .busy(busy_m), .done(done_m)
    );

    skewed_accumulator #(
        .DEPTH(D), .ARRAY_M(M), .IN_WIDTH(SW), .ACC_WIDTH(SW), .SATURATE(1)
    ) dut_sat (
        .clk(clk), .reset(reset), .data_set_in(data_small), .on(on), .first(first),
        .num_cols(num_cols), .drain(drain), .out_ready(out_ready), .out_valid(ov_s),
        .acc_out(acc_s), .busy(busy_s), .done(done_s)
    );

    skewed_accumulator #(
        .DEPTH(D), .ARRAY_M(M), .IN_WIDTH(SW), .ACC_WIDTH(SW), .SATURATE(0)
    ) dut_wrap (
        .clk(clk), .reset(reset), .data_set_in(data_small), .on(on), .first(first),
        .num_cols(num_cols), .drain(drain), .out_ready(out_ready), .out_valid(ov_w),
        .acc_out(acc_w), .busy(busy_w), .done(done_w)
    );

    int      checks = 0;
    int      failures = 0;
    int      rows_done = 0;
    longint  mem_m [M][D];
    longint  mem_s [M][D];
    longint  mem_w [M][D];
    longint  cur [M];
    wide_t   q_m [$];
    narrow_t q_s [$];
    narrow_t q_w [$];
    wide_t   held_m;
    bit      held = 1'b0;

    task automatic check(string name, longint got, longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    task automatic check_vec(string name, wide_t got, wide_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic check_ctl(string name, logic eb, logic ed);
        check({name, "_busy"}, longint'({busy_m, busy_s, busy_w}), longint'({3{eb}}));
        check({name, "_done"}, longint'({done_m, done_s, done_w}), longint'({3{ed}}));
    endtask

    function automatic longint sext(longint v, int w);
        return (v <<< (64 - w)) >>> (64 - w);
    endfunction

    function automatic longint acc_add(longint a, longint b, int w, bit sat);
        longint s  = a + b;
        longint hi = (longint'(1) <<< (w - 1)) - 1;
        longint lo = -hi - 1;
        if (!sat) return sext(s, w);
        if (s > hi) return hi;
        if (s < lo) return lo;
        return s;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < M; c++)
            for (int r = 0; r < D; r++) begin
                mem_m[c][r] = 0;
                mem_s[c][r] = 0;
                mem_w[c][r] = 0;
            end
    endfunction

    // Skew cycle t: column c receives row t-c.
    function automatic void model_step(int t, bit f, int n);
        int nn = (n > M) ? M : n;
        for (int c = 0; c < nn; c++) begin
            int r = t - c;
            if (r >= 0 && r < D) begin
                longint vm = sext(cur[c], W);
                longint vs = sext(cur[c], SW);
                mem_m[c][r] = f ? vm : acc_add(mem_m[c][r], vm, W, 1'b0);
                mem_s[c][r] = f ? vs : acc_add(mem_s[c][r], vs, SW, 1'b1);
                mem_w[c][r] = f ? vs : acc_add(mem_w[c][r], vs, SW, 1'b0);
            end
        end
    endfunction

    task automatic set_data();
        for (int c = 0; c < M; c++) begin
            data_main[c*W +: W]   = W'(cur[c]);
            data_small[c*SW +: SW] = SW'(cur[c]);
        end
    endtask

    task automatic random_data();
        for (int c = 0; c < M; c++) cur[c] = sext(longint'($urandom), W);
        set_data();
    endtask

    // kind 0: ramp (column c gets t-c), 1: constant value, 2: random data.
    task automatic run_pass(bit f, int n, int kind, longint value, int stall_t, int stall_len);
        @(negedge clk);
        first = f;
        num_cols = CW'(n);
        drain = 1'b0;
        for (int t = 0; t <= TLAST; t++) begin
            if (t == stall_t) begin
                on = 1'b0;
                for (int k = 0; k < stall_len; k++) begin
                    random_data();
                    drain = 1'($urandom);
                    @(negedge clk);
                end
            end
            for (int c = 0; c < M; c++)
                cur[c] = (kind == 0) ? longint'(t - c) :
                         (kind == 1) ? value : sext(longint'($urandom), W);
            set_data();
            on = 1'b1;
            drain = (t > 0) ? 1'($urandom) : 1'b0;
            model_step(t, f, n);
            @(negedge clk);
            if (t == 0) begin
                check_ctl("collect_start", 1'b1, 1'b0);
                first = 1'($urandom);
                num_cols = CW'($urandom);
            end
        end
        on = 1'b0;
        drain = 1'b0;
        check_ctl("done_pulse", 1'b0, 1'b1);
        @(negedge clk);
        check_ctl("done_clear", 1'b0, 1'b0);
    endtask

    task automatic run_drain(int n, int ready_pct, int stall_row, int reset_row);
        int      nn = (n > M) ? M : n;
        int      stall_cnt = 0;
        int      cycles = 0;
        bit      was_reset = 1'b0;
        wide_t   em;
        narrow_t es, ew;
        @(negedge clk);
        for (int r = 0; r < D; r++) begin
            em = '0;
            es = '0;
            ew = '0;
            for (int c = 0; c < nn; c++) begin
                em[c*W +: W]   = W'(mem_m[c][r]);
                es[c*SW +: SW] = SW'(mem_s[c][r]);
                ew[c*SW +: SW] = SW'(mem_w[c][r]);
            end
            q_m.push_back(em);
            q_s.push_back(es);
            q_w.push_back(ew);
        end
        model_clear();
        rows_done = 0;
        drain = 1'b1;
        on = 1'($urandom);
        num_cols = CW'(n);
        out_ready = 1'($urandom);
        @(negedge clk);
        check("drain_entry_valid", longint'({ov_m, ov_s, ov_w}), 0);
        check_ctl("drain_entry", 1'b1, 1'b0);
        while (busy_m && cycles < 200) begin
            drain = 1'($urandom);
            on = 1'($urandom);
            num_cols = CW'($urandom);
            if (reset_row >= 0 && rows_done == reset_row && ov_m) begin
                reset = 1'b0;
                #1;
                check("reset_valid", longint'({ov_m, ov_s, ov_w}), 0);
                check_ctl("reset_async", 1'b0, 1'b0);
                q_m.delete();
                q_s.delete();
                q_w.delete();
                model_clear();
                was_reset = 1'b1;
                drain = 1'b0;
                on = 1'b0;
                @(negedge clk);
                reset = 1'b1;
                break;
            end
            if (stall_row >= 0 && rows_done == stall_row && ov_m && stall_cnt < 3) begin
                out_ready = 1'b0;
                stall_cnt++;
            end else begin
                out_ready = ($urandom_range(0, 99) < ready_pct);
            end
            @(negedge clk);
            cycles++;
        end
        drain = 1'b0;
        on = 1'b0;
        out_ready = 1'b0;
        check("drain_end_busy", longint'(busy_m), 0);
        check("drain_end_valid", longint'({ov_m, ov_s, ov_w}), 0);
        check("drain_rows_left", longint'(q_m.size()), 0);
        if (!was_reset) check("drain_rows", longint'(rows_done), D);
    endtask

    // Compare process: sees the values the next rising edge will act on.
    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (ov_m && held) check_vec("hold_stable", acc_m, held_m);
            if (ov_m && out_ready) begin
                if (q_m.size() == 0) begin
                    check("unexpected_row", 1, 0);
                end else begin
                    check_vec("row_main", acc_m, q_m.pop_front());
                    check_vec("row_sat", wide_t'(acc_s), wide_t'(q_s.pop_front()));
                    check_vec("row_wrap", wide_t'(acc_w), wide_t'(q_w.pop_front()));
                    check("row_valid_8bit", longint'({ov_s, ov_w}), 3);
                    rows_done++;
                end
                held = 1'b0;
            end else if (ov_m) begin
                held = 1'b1;
                held_m = acc_m;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        on = 1'b0;
        first = 1'b0;
        drain = 1'b0;
        out_ready = 1'b0;
        num_cols = '0;
        data_main = '0;
        data_small = '0;
        model_clear();
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_valid_init", longint'({ov_m, ov_s, ov_w}), 0);
        check_ctl("reset_init", 1'b0, 1'b0);
        check_vec("reset_acc", acc_m, '0);
        reset = 1'b1;

        run_pass(1'b1, 8, 0, 0, -1, 0);
        check("model_ramp", mem_m[3][5], 5);
        run_drain(8, 100, -1, -1);

        run_pass(1'b1, 8, 0, 0, -1, 0);
        run_pass(1'b0, 8, 0, 0, -1, 0);
        check("model_ramp_x2", mem_m[7][7], 14);
        run_drain(8, 100, -1, -1);
        run_drain(8, 100, -1, -1);

        run_pass(1'b1, 3, 0, 0, -1, 0);
        check("model_cols3", mem_m[4][4], 0);
        run_drain(8, 100, -1, -1);

        run_pass(1'b1, 8, 1, 100, -1, 0);
        run_pass(1'b0, 8, 1, 100, -1, 0);
        check("model_sat_pos", mem_s[0][0], 127);
        check("model_wrap_pos", mem_w[0][0], -56);
        check("model_main_pos", mem_m[0][0], 200);
        run_drain(8, 100, -1, -1);
        run_pass(1'b1, 8, 1, -100, -1, 0);
        run_pass(1'b0, 8, 1, -100, -1, 0);
        check("model_sat_neg", mem_s[5][2], -128);
        check("model_wrap_neg", mem_w[5][2], 56);
        run_drain(8, 70, -1, -1);

        run_pass(1'b1, 8, 0, 0, 5, 4);
        run_drain(8, 100, 2, -1);

        run_pass(1'b1, 8, 0, 0, -1, 0);
        run_drain(8, 100, -1, 3);
        run_drain(8, 100, -1, -1);

        for (int i = 0; i < 12; i++) begin
            run_pass(1'b1, $urandom_range(0, 15), 2, 0,
                     ($urandom_range(0, 1) == 1) ? $urandom_range(1, TLAST) : -1,
                     $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1)
                run_pass(1'b0, $urandom_range(0, 15), 2, 0, -1, 0);
            run_drain($urandom_range(0, 15), 60, $urandom_range(0, D - 1), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/skewed_accumulator.md
SKEWED_ACCUMULATOR -- requirements
Module: skewed_accumulator

Interface
REQ-001 SHALL have parameter DEPTH, default 8: rows per tile, held per column.
REQ-002 SHALL have parameter ARRAY_M, default 8: number of columns (lanes).
REQ-003 SHALL have parameter IN_WIDTH, default 32: signed input element width.
REQ-004 SHALL have parameter ACC_WIDTH, default 32, with ACC_WIDTH >= IN_WIDTH: signed accumulator width.
REQ-005 SHALL have parameter SATURATE, default 0: 1 selects saturating add, 0 selects wrapping add.
REQ-006 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port data_set_in, input, ARRAY_M*IN_WIDTH bits: column c at bits [c*IN_WIDTH +: IN_WIDTH].
REQ-009 SHALL have port on, input, 1 bit: pass start and advance enable.
REQ-010 SHALL have port first, input, 1 bit: 1 overwrites, 0 accumulates; sampled at pass start.
REQ-011 SHALL have port num_cols, input, $clog2(ARRAY_M)+1 bits: active column count; sampled at pass start and at drain start.
REQ-012 SHALL have port drain, input, 1 bit: drain request.
REQ-013 SHALL have port out_ready, input, 1 bit: downstream ready.
REQ-014 SHALL have port out_valid, output, 1 bit: acc_out holds a valid row.
REQ-015 SHALL have port acc_out, output, ARRAY_M*ACC_WIDTH bits: one drained row.
REQ-016 SHALL have port busy, output, 1 bit: high when the FSM is not IDLE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a pass.

Function
REQ-018 SHALL implement the FSM states IDLE, COLLECT and DRAIN.
REQ-019 IDLE with drain=1 SHALL go to DRAIN, and drain SHALL take priority over on when both are high in the same cycle.
REQ-020 IDLE with on=1 and drain=0 SHALL go to COLLECT, sample first and num_cols, and treat that cycle's data as skew cycle t=0.
REQ-021 In COLLECT, t SHALL advance only on cycles with on=1, and on=0 SHALL stall with no write.
REQ-022 At skew cycle t, column c SHALL write row r=t-c only if 0<=r<DEPTH and c<num_cols.
REQ-023 A write SHALL store sign-extended data when first=1 and SHALL store entry+data when first=0.
REQ-024 With SATURATE=1, additions SHALL clamp to [-2^(ACC_WIDTH-1), 2^(ACC_WIDTH-1)-1]; with SATURATE=0 they SHALL wrap modulo 2^ACC_WIDTH.
REQ-025 After the on=1 cycle with t=DEPTH+ARRAY_M-2, the FSM SHALL enter IDLE and done SHALL be high for exactly the next cycle.
REQ-026 num_cols=0 SHALL produce no writes, and num_cols>ARRAY_M SHALL be treated as ARRAY_M.
REQ-027 In DRAIN, rows 0..DEPTH-1 SHALL be presented in order, with out_valid first asserted one cycle after DRAIN entry.
REQ-028 A row SHALL be transferred on out_valid&&out_ready, and while out_valid&&!out_ready acc_out SHALL be held stable.
REQ-029 Columns c>=num_cols SHALL read as 0 in acc_out.
REQ-030 Each transferred row's entries SHALL be cleared to 0 (read-and-clear).
REQ-031 After the row DEPTH-1 handshake, out_valid SHALL drop in the next cycle and the FSM SHALL return to IDLE.
REQ-032 on and drain SHALL be ignored outside IDLE.

Reset
REQ-033 On reset=0, asynchronously: state=IDLE, t=0, all storage=0, acc_out=0, out_valid=0, busy=0, done=0.
REQ-034 Reset mid-COLLECT or mid-DRAIN SHALL abandon the operation with no partial output.

Structure
REQ-035 A shared package SHALL hold the state enum and a sign-extend/saturating-add function parameterised by ACC_WIDTH.
REQ-036 The sub-module acc_lane SHALL hold one column's DEPTH entries, the add/overwrite logic and the clear logic, and SHALL be instantiated ARRAY_M times.
REQ-037 The top level SHALL hold the FSM, the skew counter and the drain row counter.

Verification (defaults unless stated)
REQ-038 Ramp: first=1, num_cols=8, column c fed r at t=r+c for 15 cycles, then drain -> row r = {r,...,r} for r=0..7; done pulses once.
REQ-039 Repeat the ramp twice (first=1, then first=0), then drain -> row r = 2r in all columns; a second drain -> all zeros.
REQ-040 num_cols=3 ramp, then drain -> columns 0-2 = r, columns 3-7 = 0.
REQ-041 SATURATE=1, IN_WIDTH=ACC_WIDTH=8, value 100 accumulated twice -> 127; value -100 twice -> -128; SATURATE=0 with 100 twice -> -56.
REQ-042 on=0 for 4 cycles at t=5 during the ramp, and out_ready=0 for 3 cycles at row 2 -> results identical to REQ-038, acc_out stable while stalled.
REQ-043 reset=0 for one cycle at drain row 3 -> out_valid=0 and busy=0 immediately, and a subsequent drain returns all zeros.
